// File: rtl/sevenseg_scan_sequencer_if.sv
// Interface for the seven-segment scan sequencer.
// It groups the CPU-side write bus, the live masks and the board-pin outputs.
//   master : CPU or testbench side. It drives wr_en, wr_data, digit_mask and dp_mask,
//            and it observes segments, AN, pending and frame_done.
//   slave  : the sequencer, which sees the same signals with the directions reversed.
interface sevenseg_scan_sequencer_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  digit_mask;
  logic [7:0]  dp_mask;
  logic [7:0]  segments;
  logic [7:0]  AN;
  logic        pending;
  logic        frame_done;

  modport master (
    output wr_en, wr_data, digit_mask, dp_mask,
    input  segments, AN, pending, frame_done
  );

  modport slave (
    input  wr_en, wr_data, digit_mask, dp_mask,
    output segments, AN, pending, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_sequencer.sv
// Seven-segment scan sequencer.
// It time-multiplexes a 32-bit hex word onto an 8-digit common-anode display.
//
// Behaviour:
//   - Writes are double-buffered per frame. A CPU write goes into a pending buffer.
//     It becomes the displayed word only at the next frame boundary.
//   - Each digit slot lasts REFRESH_DIV clocks.
//   - The first BLANK_CYCLES clocks of every slot are blanked to suppress ghosting.
//
// Ports:
//   CLK100MHZ : system clock. All state updates on its rising edge.
//   reset     : asynchronous, active-high.
//   bus       : slave modport of sevenseg_scan_sequencer_if.
//     wr_en, wr_data        : single-cycle write strobe and word. Nibble d drives digit d.
//     digit_mask, dp_mask   : per-digit enable and decimal point, sampled live.
//     segments              : active-low, [7]=dp, [6:0]=g..a.
//     AN                    : active-low digit enables.
//     pending               : a written word is waiting for the frame boundary.
//     frame_done            : one-cycle pulse at the end of digit 7's slot.
//
// Parameter constraint: 1 <= BLANK_CYCLES < REFRESH_DIV.
module sevenseg_scan_sequencer #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                       CLK100MHZ,
  input  logic                       reset,
  sevenseg_scan_sequencer_if.slave   bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic {BLANK, SHOW} state_t;

  // Scan position (stage p0) and registered pin drive (stage p1).
  state_t        state_p0;
  logic [CW-1:0] cnt_p0;
  logic [2:0]    digit_p0;
  logic [7:0]    seg_p1;
  logic [7:0]    an_p1;

  logic [31:0]   active_word;
  logic [31:0]   pend_buf;
  logic          pending_q;
  logic          frame_done_q;

  logic [CW-1:0] cnt_nxt;
  logic          slot_wrap;
  logic          frame_edge;
  logic [3:0]    nibble;

  // Hex to segments g..a, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap  = (cnt_p0 == CNT_LAST);
    cnt_nxt    = slot_wrap ? '0 : cnt_p0 + CW'(1);
    frame_edge = slot_wrap && (digit_p0 == 3'd7);
    nibble     = active_word[{digit_p0, 2'b00} +: 4];
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_p0     <= BLANK;
      cnt_p0       <= '0;
      digit_p0     <= 3'd0;
      seg_p1       <= 8'hFF;
      an_p1        <= 8'hFF;
      active_word  <= 32'h0;
      pend_buf     <= 32'h0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // ---- stage p1: pins follow the state one edge after it was entered
      if (state_p0 == SHOW && bus.digit_mask[digit_p0]) begin
        an_p1  <= ~(8'h01 << digit_p0);
        seg_p1 <= {~bus.dp_mask[digit_p0], hex7(nibble)};
      end else begin
        an_p1  <= 8'hFF;
        seg_p1 <= 8'hFF;
      end

      // ---- stage p0: slot counter, digit index and blank/show state
      cnt_p0 <= cnt_nxt;
      if (slot_wrap) digit_p0 <= digit_p0 + 3'd1;
      state_p0 <= (cnt_nxt < CNT_BLANK) ? BLANK : SHOW;

      // The displayed word only changes on the frame edge.
      // A write on that same edge bypasses the stale buffer.
      frame_done_q <= frame_edge;
      if (frame_edge) begin
        if (bus.wr_en)      active_word <= bus.wr_data;
        else if (pending_q) active_word <= pend_buf;
        pending_q <= 1'b0;
      end else if (bus.wr_en) begin
        pend_buf  <= bus.wr_data;
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.segments   = seg_p1;
  assign bus.AN         = an_p1;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_sequencer.sv
// Self-checking bench for sevenseg_scan_sequencer.
// It uses a small slot, REFRESH_DIV=16 and BLANK_CYCLES=4.
module tb_sevenseg_scan_sequencer;
  localparam int RD = 16;
  localparam int BL = 4;

  logic CLK100MHZ = 1'b0;
  logic reset;
  sevenseg_scan_sequencer_if bus();

  sevenseg_scan_sequencer #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       pend;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state, as it stands before the next edge.
  int          m_cnt, m_digit;
  logic [31:0] m_active, m_pbuf;
  logic        m_pend;

  function automatic logic [6:0] ref_hex(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_digit = 0; m_active = 0; m_pbuf = 0; m_pend = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    bus.wr_en = 0; bus.wr_data = 0;
    reset = 1;
    repeat (2) @(posedge CLK100MHZ);
    #1 reset = 0;
    model_clear();
  endtask

  // Advance one clock edge.
  // The model predicts the outputs for the current inputs and pushes them,
  // then the DUT outputs after the edge are popped and compared.
  task automatic step();
    exp_t e, got;
    logic bnd;
    if (m_cnt >= BL && bus.digit_mask[m_digit]) begin
      e.an  = ~(8'h01 << m_digit);
      e.seg = {~bus.dp_mask[m_digit], ref_hex(m_active[m_digit*4 +: 4])};
    end else begin
      e.an = 8'hFF; e.seg = 8'hFF;
    end
    bnd = (m_cnt == RD-1) && (m_digit == 7);
    e.fd = bnd;
    if (bnd) begin
      if (bus.wr_en) m_active = bus.wr_data;
      else if (m_pend) m_active = m_pbuf;
      m_pend = 0;
    end else if (bus.wr_en) begin
      m_pbuf = bus.wr_data; m_pend = 1;
    end
    e.pend = m_pend;
    m_cnt++;
    if (m_cnt == RD) begin m_cnt = 0; m_digit = (m_digit + 1) % 8; end
    sb.push_back(e);
    @(posedge CLK100MHZ); #1;
    e = sb.pop_front();
    got = '{bus.AN, bus.segments, bus.pending, bus.frame_done};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL sb t=%0t AN=%h seg=%h pend=%b fd=%b required AN=%h seg=%h pend=%b fd=%b",
               $time, got.an, got.seg, got.pend, got.fd, e.an, e.seg, e.pend, e.fd);
    end
  endtask

  task automatic test_reset();
    reset = 1; bus.wr_en = 0; bus.wr_data = 0;
    #12;
    vectors++;
    if ({bus.AN, bus.segments, bus.pending, bus.frame_done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state AN=%h seg=%h pend=%b fd=%b required FF FF 0 0",
               bus.AN, bus.segments, bus.pending, bus.frame_done);
    end
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step();
      vectors++;
      if (e >= 5 && e <= 16) begin
        if (bus.AN !== 8'hFE || bus.segments !== 8'hC0) begin
          miscompares++;
          $display("FAIL slot0_show edge=%0d AN=%h seg=%h required FE C0", e, bus.AN, bus.segments);
        end
      end else if (bus.AN !== 8'hFF) begin
        miscompares++;
        $display("FAIL slot_blank edge=%0d AN=%h required FF", e, bus.AN);
      end
    end
  endtask

  task automatic test_write_latency();
    bit seen;
    do_reset();
    repeat (29) step();
    bus.wr_en = 1; bus.wr_data = 32'h12345678;
    step();
    bus.wr_en = 0;
    vectors++;
    if (bus.pending !== 1'b1) begin
      miscompares++; $display("FAIL pending_set pend=%b required 1", bus.pending);
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (bus.frame_done === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || bus.pending !== 1'b0) begin
      miscompares++; $display("FAIL frame_swap seen=%b pend=%b required 1 0", seen, bus.pending);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin step(); if (bus.AN === 8'hFE) seen = 1; end
    vectors++;
    if (!seen || bus.segments !== 8'h80) begin
      miscompares++; $display("FAIL digit0_new seen=%b seg=%h required 80", seen, bus.segments);
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin step(); if (bus.AN === 8'h7F) seen = 1; end
    vectors++;
    if (!seen || bus.segments !== 8'hF9) begin
      miscompares++; $display("FAIL digit7_new seen=%b seg=%h required F9", seen, bus.segments);
    end
  endtask

  task automatic test_slot_timing();
    int low [8];
    int ff_cnt, entries, fd_first, fd_second;
    logic [7:0] prev;
    do_reset();
    for (int d = 0; d < 8; d++) low[d] = 0;
    ff_cnt = 0; entries = 0; fd_first = -1; fd_second = -1; prev = 8'hFF;
    for (int e = 1; e <= 256; e++) begin
      step();
      if (bus.frame_done === 1'b1) begin
        if (fd_first < 0) fd_first = e; else if (fd_second < 0) fd_second = e;
      end
      if (e > 128) begin
        if (bus.AN === 8'hFF) ff_cnt++;
        else if (prev === 8'hFF) entries++;
        for (int d = 0; d < 8; d++) if (bus.AN === ~(8'h01 << d)) low[d]++;
      end
      prev = bus.AN;
    end
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (low[d] != 12) begin
        miscompares++; $display("FAIL an_low digit=%0d cycles=%0d required 12", d, low[d]);
      end
    end
    vectors++;
    if (ff_cnt != 32 || entries != 8) begin
      miscompares++; $display("FAIL blank_gaps ff=%0d runs=%0d required 32 8", ff_cnt, entries);
    end
    vectors++;
    if (fd_first != 128 || fd_second != 256) begin
      miscompares++; $display("FAIL fd_period first=%0d second=%0d required 128 256", fd_first, fd_second);
    end
  endtask

  task automatic test_masks();
    bit seen;
    do_reset();
    bus.digit_mask = 8'hFE; bus.dp_mask = 8'h02;
    step();
    bus.wr_en = 1; bus.wr_data = 32'h000000A0;
    step();
    bus.wr_en = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin step(); if (bus.frame_done === 1'b1) seen = 1; end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL mask_frame timeout=1 required frame_done"); end
    for (int j = 1; j <= 21; j++) begin
      step();
      if (j <= 16) begin
        vectors++;
        if (bus.AN !== 8'hFF) begin
          miscompares++; $display("FAIL mask_off edge=%0d AN=%h required FF", j, bus.AN);
        end
      end else if (j == 21) begin
        vectors++;
        if (bus.AN !== 8'hFD || bus.segments !== 8'h08) begin
          miscompares++; $display("FAIL dp_digit1 AN=%h seg=%h required FD 08", bus.AN, bus.segments);
        end
      end
    end
    bus.digit_mask = 8'hFF; bus.dp_mask = 8'h00;
  endtask

  task automatic test_back_to_back();
    int guard;
    int bad;
    bit seen;
    do_reset();
    repeat (5) step();
    bus.wr_en = 1; bus.wr_data = 32'h11111111;
    step();
    bus.wr_en = 0;
    guard = 0;
    while (!(m_cnt == RD-1 && m_digit == 7) && guard < 200) begin step(); guard++; end
    bus.wr_en = 1; bus.wr_data = 32'hDEADBEEF;
    step();
    bus.wr_en = 0;
    vectors++;
    if (bus.frame_done !== 1'b1 || bus.pending !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_edge fd=%b pend=%b required 1 0", bus.frame_done, bus.pending);
    end
    bad = 0; seen = 0;
    for (int i = 0; i < 128; i++) begin
      step();
      if (bus.AN !== 8'hFF && bus.segments[6:0] === 7'h79) bad++;
      if (bus.AN === 8'hFE && !seen) begin
        seen = 1;
        vectors++;
        if (bus.segments !== 8'h8E) begin
          miscompares++; $display("FAIL b2b_digit0 seg=%h required 8E", bus.segments);
        end
      end
    end
    vectors++;
    if (bad != 0 || !seen) begin
      miscompares++; $display("FAIL stale_word shown=%0d seen=%b required 0 1", bad, seen);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    repeat (9) step();
    bus.wr_en = 1; bus.wr_data = 32'h12345678;
    step();
    bus.wr_en = 0;
    repeat (50) step();
    vectors++;
    if (bus.AN !== 8'hF7 || bus.pending !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset AN=%h pend=%b required F7 1", bus.AN, bus.pending);
    end
    #1 reset = 1;
    #1;
    vectors++;
    if ({bus.AN, bus.segments, bus.pending} !== {8'hFF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset AN=%h seg=%h pend=%b required FF FF 0", bus.AN, bus.segments, bus.pending);
    end
    do_reset();
    for (int e = 1; e <= 5; e++) step();
    vectors++;
    if (bus.AN !== 8'hFE || bus.segments !== 8'hC0 || bus.pending !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset AN=%h seg=%h pend=%b required FE C0 0", bus.AN, bus.segments, bus.pending);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 0; bus.wr_data = 0;
    bus.digit_mask = 8'hFF; bus.dp_mask = 8'h00;
    reset = 1;
    model_clear();
    test_reset();
    test_write_latency();
    test_slot_timing();
    test_masks();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
